// File: rtl/four_12_12_st1_mem_arb_pkg.sv
// rtl/four_12_12_st1_mem_arb_pkg.sv - shared types and constants for the two-port memory arbiter
// Purpose: memory geometry constants, the memory command struct and the
//          arbiter state encoding shared by the top and the arbiter.
// Ports:   none (package).
package four_12_12_st1_mem_arb_pkg;

  localparam int MEM_ADDR_W = 9;
  localparam int MEM_DATA_W = 32;

  typedef struct packed {
    logic                  rd_en;
    logic                  wr_en;
    logic [MEM_ADDR_W-1:0] addr;
  } data_int_32_9;

  // LAST_x: port x won the last accept without lock, so the other port is
  // preferred on contention. LOCK_x: port x won with lock and is favoured
  // for exactly one more cycle.
  typedef enum logic [1:0] {
    ST_LAST_A = 2'd0,
    ST_LAST_B = 2'd1,
    ST_LOCK_A = 2'd2,
    ST_LOCK_B = 2'd3
  } arb_state_e;

endpackage

// File: rtl/four_12_12_st1_mem_arb_rr_arb_2.sv
// rtl/four_12_12_st1_mem_arb_rr_arb_2.sv - two-way round-robin arbiter with one-cycle lock
// Purpose: combinational grant from requests, last-grant pointer and lock.
// Ports:   clk, rst_n (async, active-low); a_req/a_lock, b_req/b_lock in;
//          a_gnt/b_gnt out (both 0 while reset is asserted).
import four_12_12_st1_mem_arb_pkg::*;

module rr_arb_2 (
  input  logic clk,
  input  logic rst_n,
  input  logic a_req,
  input  logic a_lock,
  input  logic b_req,
  input  logic b_lock,
  output logic a_gnt,
  output logic b_gnt
);

  arb_state_e state, state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_LAST_B;
    else        state <= state_nxt;
  end

  always_comb begin
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    state_nxt = state;
    if (rst_n) begin
      unique case (state)
        ST_LOCK_A: begin
          if (a_req)      a_gnt = 1'b1;
          else if (b_req) b_gnt = 1'b1;
        end
        ST_LOCK_B: begin
          if (b_req)      b_gnt = 1'b1;
          else if (a_req) a_gnt = 1'b1;
        end
        ST_LAST_A: begin
          if (b_req)      b_gnt = 1'b1;
          else if (a_req) a_gnt = 1'b1;
        end
        default: begin
          if (a_req)      a_gnt = 1'b1;
          else if (b_req) b_gnt = 1'b1;
        end
      endcase
      // Lock is re-evaluated on every accept, so it never outlives one
      // extra grant unless the owner asserts it again.
      if (a_gnt)      state_nxt = a_lock ? ST_LOCK_A : ST_LAST_A;
      else if (b_gnt) state_nxt = b_lock ? ST_LOCK_B : ST_LAST_B;
    end
  end

endmodule

// File: rtl/four_12_12_st1_mem_arb.sv
// rtl/four_12_12_st1_mem_arb.sv - two-port arbiter in front of a single-port synchronous memory
// Purpose: arbitrate ports A/B onto one memory command path, route read
//          responses back via a 2-stage tag pipeline, count accepts.
// Ports:   clk, rst_n (async, active-low);
//          a_/b_ req, wr, lock, addr, wdata in; gnt, rsp_valid, rsp_data out;
//          mem (rd_en/wr_en/addr), mem_wr_data out; mem_rd_data in;
//          a_count, b_count out.
import four_12_12_st1_mem_arb_pkg::*;

module four_12_12_st1_mem_arb #(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_wr,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_data,
  input  logic              b_req,
  input  logic              b_wr,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_data,
  output data_int_32_9      mem,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [CNT_W-1:0]  a_count,
  output logic [CNT_W-1:0]  b_count
);

  logic a_acc, b_acc;
  // Tag stage 1 aligns with the memory command, stage 2 with read data.
  logic tag1_valid, tag1_b;
  logic tag2_valid, tag2_b;

  rr_arb_2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_req  (a_req),
    .a_lock (a_lock),
    .b_req  (b_req),
    .b_lock (b_lock),
    .a_gnt  (a_gnt),
    .b_gnt  (b_gnt)
  );

  assign a_acc = a_req & a_gnt;
  assign b_acc = b_req & b_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem         <= '0;
      mem_wr_data <= '0;
      tag1_valid  <= 1'b0;
      tag1_b      <= 1'b0;
      tag2_valid  <= 1'b0;
      tag2_b      <= 1'b0;
      a_count     <= '0;
      b_count     <= '0;
    end else begin
      mem.rd_en  <= 1'b0;
      mem.wr_en  <= 1'b0;
      tag1_valid <= 1'b0;
      if (a_acc) begin
        mem.rd_en   <= ~a_wr;
        mem.wr_en   <= a_wr;
        mem.addr    <= a_addr;
        mem_wr_data <= a_wdata;
        tag1_valid  <= ~a_wr;
        tag1_b      <= 1'b0;
        a_count     <= a_count + CNT_W'(1);
      end else if (b_acc) begin
        mem.rd_en   <= ~b_wr;
        mem.wr_en   <= b_wr;
        mem.addr    <= b_addr;
        mem_wr_data <= b_wdata;
        tag1_valid  <= ~b_wr;
        tag1_b      <= 1'b1;
        b_count     <= b_count + CNT_W'(1);
      end
      tag2_valid <= tag1_valid;
      tag2_b     <= tag1_b;
    end
  end

  assign a_rsp_valid = tag2_valid & ~tag2_b;
  assign b_rsp_valid = tag2_valid &  tag2_b;
  assign a_rsp_data  = a_rsp_valid ? mem_rd_data : '0;
  assign b_rsp_data  = b_rsp_valid ? mem_rd_data : '0;

endmodule

// File: doc/four_12_12_st1_mem_arb.md
FOUR_12_12_ST1_MEM_ARB -- requirements
Module: four_12_12_st1_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, memory address width (512 entries).
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter CNT_W, default 16, per-port transaction counter width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 a_req  input  1  port A request valid.
REQ-007 a_wr  input  1  port A: 1 = write, 0 = read.
REQ-008 a_lock  input  1  port A holds grant on the following cycle (read-modify-write).
REQ-009 a_addr  input  ADDR_W  port A address.
REQ-010 a_wdata  input  DATA_W  port A write data.
REQ-011 a_gnt  output  1  port A accepted this cycle.
REQ-012 a_rsp_valid  output  1  port A read data valid.
REQ-013 a_rsp_data  output  DATA_W  port A read data.
REQ-014 b_* signals SHALL mirror REQ-006..REQ-013 for port B.
REQ-015 mem  output  data_int_32_9  memory port struct: rd_en, wr_en, addr.
REQ-016 mem_wr_data  output  DATA_W  memory write data.
REQ-017 mem_rd_data  input  DATA_W  memory read data, valid one cycle after rd_en.
REQ-018 a_count, b_count  output  CNT_W each  accepted-transaction counters.

Function
REQ-019 A transaction SHALL be accepted in the cycle where x_req and x_gnt are both 1; at most one grant per cycle.
REQ-020 Grant SHALL be combinational from the requests, the last-grant pointer and the lock state.
REQ-021 If only one port requests, that port SHALL be granted.
REQ-022 If both request, the port not granted last SHALL be granted; the pointer updates on every accept.
REQ-023 If the last accept carried x_lock=1 and x_req=1, port x SHALL be granted regardless of the pointer; lock SHALL NOT persist beyond one extra grant unless reasserted.
REQ-024 Accept in cycle N SHALL drive registered mem.rd_en/wr_en, addr and mem_wr_data during N+1; with no accept, rd_en and wr_en SHALL be 0 in N+1.
REQ-025 A read accepted in N SHALL assert x_rsp_valid during N+2 only, with x_rsp_data = mem_rd_data.
REQ-026 Writes SHALL produce no response.
REQ-027 A 2-stage tag pipeline (valid, port) SHALL route responses; sustained throughput is one access per cycle.
REQ-028 A read in N+1 after a write to the same address in N SHALL return the new data; ordering is preserved by the single issue path.
REQ-029 x_count SHALL increment by 1 on each port-x accept and wrap from 2^CNT_W-1 to 0.
REQ-030 x_rsp_data SHALL be 0 when x_rsp_valid is 0.

Reset
REQ-031 Reset assertion SHALL immediately clear mem command outputs, tag pipeline, lock state and counters to 0; the pointer SHALL be set to B so A wins the first contention.
REQ-032 Reads in flight at reset SHALL be dropped with no response after reset release.
REQ-033 Grants SHALL be 0 while reset is asserted.

Structure
REQ-034 data_int_32_9 and the ADDR_W/DATA_W constants SHALL come from the shared types.v package; no new typedefs local to the block.
REQ-035 The two-way round-robin/lock grant logic SHALL be one sub-module, rr_arb_2; everything else is inline.

Verification
REQ-036 A reads 0x010 alone at N -> a_gnt=1 at N, mem.rd_en=1/addr=0x010 at N+1, a_rsp_valid=1 with memory content at N+2, b_rsp_valid stays 0.
REQ-037 A and B both request continuously for 6 cycles after reset -> grants A,B,A,B,A,B; a_count=3, b_count=3.
REQ-038 B writes 0xDEADBEEF to 0x1FF at N, A reads 0x1FF at N+1 -> a_rsp_data=0xDEADBEEF at N+3.
REQ-039 A with a_lock=1 reads 0x020 while B requests -> A granted two consecutive cycles, then B.
REQ-040 Reset asserted one cycle after a read accept -> no response ever appears; mem.rd_en=0 immediately; counters=0.
REQ-041 Drive 2^16 A accepts -> a_count wraps to 0.
